// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, state codes, datapath selects
// and the Moore control word produced for each state.
package multicycle_control_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam int unsigned WaitCntW = 8;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StJump   = 4'd12
    } state_e;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational state -> control-word decoder (Moore outputs of the multi-cycle controller).
module mc_ctrl_out_decode
    import multicycle_control_pkg::*;
(
    input  state_e     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = AluOpAdd;
        ctrl.pc_source = PcSrcAlu;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBImmSh;
            end
            StMemAdr, StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = AluOpSub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PcSrcAluOut;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcSrcJump;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, PCEn combine and, when
// MC_CTRL_MEM_WAIT_EN is defined, memory wait handling with a timeout counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic [STATE_W-1:0] state
);

    if (STATE_W < 4) begin : g_state_w_check
        $error("STATE_W must be at least 4");
    end
    if (MEM_TIMEOUT > (2 ** WaitCntW) - 1) begin : g_timeout_check
        $error("MEM_TIMEOUT does not fit the wait counter");
    end

    state_e     state_q, state_d;
    logic       run_q;
    ctrl_word_t ctrl;
    logic       fetch_gate;

    // run_q keeps the FSM in IDLE for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

`ifdef MC_CTRL_MEM_WAIT_EN
    logic                wait_state;
    logic                mem_hold;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;

    assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign fetch_gate = (state_q != StFetch) || mem_ready;

    always_comb begin
        if (!mem_hold) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == '1) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign fetch_gate  = 1'b1;
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            StIdle:   if (run_q) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (Opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StMemWr, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
            default:  state_d = StIdle;
        endcase
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_timeout = 1'b0;
        mem_hold    = 1'b0;
        if (wait_state && !mem_ready) begin
            // On timeout the in-flight instruction is abandoned and fetch restarts.
            if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WaitCntW'(MEM_TIMEOUT))) begin
                mem_timeout = 1'b1;
                state_d     = StFetch;
            end else begin
                mem_hold = 1'b1;
                state_d  = state_q;
            end
        end
`endif
    end

    mc_ctrl_out_decode u_out_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign PCEn     = (ctrl.pc_write & fetch_gate) | (ctrl.pc_write_cond & Zero);
    assign IorD     = ctrl.i_or_d;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write & fetch_gate;
    assign RegWrite = ctrl.reg_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSource = ctrl.pc_source;
    assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state
// sequence and compares the state and full control word every cycle against hand-coded values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;
    logic [16:0] word;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .STATE_W     (4),
`ifdef MC_CTRL_MEM_WAIT_EN
        .MEM_TIMEOUT (4)
`else
        .MEM_TIMEOUT (255)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .Zero        (Zero),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .PCEn        (PCEn),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    assign word = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, illegal_op, mem_timeout};

    function automatic logic [16:0] cw(input logic pcen, input logic iord, input logic mrd,
                                       input logic mwr, input logic irw, input logic rgw,
                                       input logic m2r, input logic rdst, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] aluop,
                                       input logic [1:0] pcsrc, input logic ill,
                                       input logic tmo);
        return {pcen, iord, mrd, mwr, irw, rgw, m2r, rdst, srca, srcb, aluop, pcsrc, ill, tmo};
    endfunction

    localparam logic [16:0] W_IDLE    = 17'h0;
    localparam logic [16:0] W_FETCH   = cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_DECODE  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_DEC_ILL = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
    localparam logic [16:0] W_MEMADR  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                           2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_MEMRD   = cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_MEMWB   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_MEMWR   = cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_EXEC    = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                           2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_ALUWB   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_BR_T    = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                           2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
    localparam logic [16:0] W_BR_N    = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                           2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
    localparam logic [16:0] W_ADDIWB  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_JUMP    = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
`ifdef MC_CTRL_MEM_WAIT_EN
    localparam logic [16:0] W_FETCH_WAIT = cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                              1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    localparam logic [16:0] W_MEMRD_TO   = cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                              1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [16:0] w);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " ctrl"}, 32'(word), 32'(w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        Opcode = 6'b100011;
        Zero   = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        #2;
        expect_cycle("in_reset", 4'd0, W_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick(); expect_cycle("release_edge1", 4'd0, W_IDLE);
        tick(); expect_cycle("release_edge2", 4'd1, W_FETCH);

        // lw
        tick(); expect_cycle("lw_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("lw_memadr", 4'd3, W_MEMADR);
        tick(); expect_cycle("lw_memrd", 4'd4, W_MEMRD);
        tick(); expect_cycle("lw_memwb", 4'd5, W_MEMWB);
        tick(); expect_cycle("lw_fetch", 4'd1, W_FETCH);

        // sw
        Opcode = 6'b101011;
        tick(); expect_cycle("sw_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("sw_memadr", 4'd3, W_MEMADR);
        tick(); expect_cycle("sw_memwr", 4'd6, W_MEMWR);
        tick(); expect_cycle("sw_fetch", 4'd1, W_FETCH);

        // R-type
        Opcode = 6'b000000;
        tick(); expect_cycle("r_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("r_exec", 4'd7, W_EXEC);
        tick(); expect_cycle("r_aluwb", 4'd8, W_ALUWB);
        tick(); expect_cycle("r_fetch", 4'd1, W_FETCH);

        // addi
        Opcode = 6'b001000;
        tick(); expect_cycle("addi_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("addi_ex", 4'd10, W_MEMADR);
        tick(); expect_cycle("addi_wb", 4'd11, W_ADDIWB);
        tick(); expect_cycle("addi_fetch", 4'd1, W_FETCH);

        // beq taken
        Opcode = 6'b000100;
        Zero   = 1'b1;
        tick(); expect_cycle("beq_t_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("beq_t_branch", 4'd9, W_BR_T);
        tick(); expect_cycle("beq_t_fetch", 4'd1, W_FETCH);

        // beq not taken
        Zero = 1'b0;
        tick(); expect_cycle("beq_n_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("beq_n_branch", 4'd9, W_BR_N);
        tick(); expect_cycle("beq_n_fetch", 4'd1, W_FETCH);

        // j
        Opcode = 6'b000010;
        tick(); expect_cycle("j_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("j_jump", 4'd12, W_JUMP);
        tick(); expect_cycle("j_fetch", 4'd1, W_FETCH);

        // unsupported opcode
        Opcode = 6'b111111;
        tick(); expect_cycle("ill_decode", 4'd2, W_DEC_ILL);
        tick(); expect_cycle("ill_fetch", 4'd1, W_FETCH);

        // reset asserted in the middle of lw
        Opcode = 6'b100011;
        tick(); expect_cycle("rst_lw_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("rst_lw_memadr", 4'd3, W_MEMADR);
        tick(); expect_cycle("rst_lw_memrd", 4'd4, W_MEMRD);
        rst_n = 1'b0;
        #1;
        expect_cycle("rst_mid_memrd", 4'd0, W_IDLE);
        tick(); expect_cycle("rst_held", 4'd0, W_IDLE);
        rst_n = 1'b1;
        tick(); expect_cycle("rerelease_edge1", 4'd0, W_IDLE);
        tick(); expect_cycle("rerelease_edge2", 4'd1, W_FETCH);

`ifdef MC_CTRL_MEM_WAIT_EN
        // FETCH held two cycles by memory
        mem_ready = 1'b0;
        #1;
        expect_cycle("fetch_wait1", 4'd1, W_FETCH_WAIT);
        tick(); expect_cycle("fetch_wait2", 4'd1, W_FETCH_WAIT);
        tick();
        mem_ready = 1'b1;
        #1;
        expect_cycle("fetch_ready", 4'd1, W_FETCH);
        tick(); expect_cycle("to_decode", 4'd2, W_DECODE);
        tick(); expect_cycle("to_memadr", 4'd3, W_MEMADR);
        // MEMRD never completes: four held cycles then the timeout pulse
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_cycle("memrd_wait", 4'd4, W_MEMRD);
        end
        tick(); expect_cycle("memrd_timeout", 4'd4, W_MEMRD_TO);
        tick();
        mem_ready = 1'b1;
        #1;
        expect_cycle("timeout_fetch", 4'd1, W_FETCH);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
